// File: rtl/spi_ram_param_if.sv
// rtl/spi_ram_param_if.sv - command/response bus between SPI deserialiser and RAM slave
interface spi_ram_param_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH+1:0] din;
    logic                  rx_valid;
    logic [DATA_WIDTH-1:0] dout;
    logic                  tx_valid;
    logic                  addr_err;

    modport master (
        output din,
        output rx_valid,
        input  dout,
        input  tx_valid,
        input  addr_err
    );

    modport slave (
        input  din,
        input  rx_valid,
        output dout,
        output tx_valid,
        output addr_err
    );
endinterface

// File: rtl/spi_ram_param.sv
// rtl/spi_ram_param.sv - parametrised SPI RAM slave with pointer auto-increment and sticky range error
module spi_ram_param #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8,
    parameter int MEM_DEPTH  = 256,
    parameter bit AUTO_INC   = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    spi_ram_param_if.slave bus
);

    typedef enum logic [1:0] {
        OP_WR_ADDR = 2'b00,
        OP_WR_DATA = 2'b01,
        OP_RD_ADDR = 2'b10,
        OP_RD_DATA = 2'b11
    } op_t;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    // One extra bit so MEM_DEPTH == 2**ADDR_WIDTH is representable in the range check.
    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH+1)'(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  addr_err_q;
    state_t                state_q;
    state_t                state_d;

    op_t                   op;
    logic [DATA_WIDTH-1:0] payload;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic                  addr_ok;
    logic [ADDR_WIDTH-1:0] wr_ptr_inc;
    logic [ADDR_WIDTH-1:0] rd_ptr_inc;

    assign op         = op_t'(bus.din[DATA_WIDTH+1:DATA_WIDTH]);
    assign payload    = bus.din[DATA_WIDTH-1:0];
    assign cmd_addr   = bus.din[ADDR_WIDTH-1:0];
    assign addr_ok    = {1'b0, cmd_addr} < DEPTH_EXT;
    assign wr_ptr_inc = (wr_ptr == LAST_ADDR) ? '0 : wr_ptr + 1'b1;
    assign rd_ptr_inc = (rd_ptr == LAST_ADDR) ? '0 : rd_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE: if (bus.rx_valid && op == OP_RD_DATA) state_d = RESP;
            RESP: if (bus.rx_valid && op == OP_RD_DATA) state_d = RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            dout_q     <= '0;
            addr_err_q <= 1'b0;
        end else if (bus.rx_valid) begin
            case (op)
                OP_WR_ADDR: begin
                    if (addr_ok) wr_ptr <= cmd_addr;
                    else         addr_err_q <= 1'b1;
                end
                OP_WR_DATA: begin
                    if (AUTO_INC) wr_ptr <= wr_ptr_inc;
                end
                OP_RD_ADDR: begin
                    if (addr_ok) rd_ptr <= cmd_addr;
                    else         addr_err_q <= 1'b1;
                end
                OP_RD_DATA: begin
                    dout_q <= mem[rd_ptr];
                    if (AUTO_INC) rd_ptr <= rd_ptr_inc;
                end
                default: ;
            endcase
        end
    end

    // Whole array clears on the reset edge; reset also blocks a same-edge write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (bus.rx_valid && op == OP_WR_DATA) begin
            mem[wr_ptr] <= payload;
        end
    end

    assign bus.dout     = dout_q;
    assign bus.tx_valid = (state_q == RESP);
    assign bus.addr_err = addr_err_q;

endmodule

// File: tb/tb_spi_ram_param.sv
// tb/tb_spi_ram_param.sv - table, directed and random checks of three spi_ram_param configurations
module tb_spi_ram_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_d;
    logic [9:0] din_d;

    always #5 clk = ~clk;

    spi_ram_param_if #(.DATA_WIDTH(8)) if0 ();
    spi_ram_param_if #(.DATA_WIDTH(8)) if1 ();
    spi_ram_param_if #(.DATA_WIDTH(8)) if2 ();

    assign if0.din = din_d;  assign if0.rx_valid = rx_d;
    assign if1.din = din_d;  assign if1.rx_valid = rx_d;
    assign if2.din = din_d;  assign if2.rx_valid = rx_d;

    spi_ram_param #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MEM_DEPTH(256), .AUTO_INC(1'b1))
        dut0 (.clk(clk), .rst(rst), .bus(if0));
    spi_ram_param #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MEM_DEPTH(256), .AUTO_INC(1'b0))
        dut1 (.clk(clk), .rst(rst), .bus(if1));
    spi_ram_param #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .MEM_DEPTH(200), .AUTO_INC(1'b1))
        dut2 (.clk(clk), .rst(rst), .bus(if2));

    int n_vec  = 0;
    int n_fail = 0;

    // Reference model: one memory image and pointer pair per instance.
    bit [7:0] m_mem [3][256];
    int       m_wr  [3];
    int       m_rd  [3];
    bit [7:0] m_dout[3];
    bit       m_tx  [3];
    bit       m_err [3];

    function automatic int depth_of(input int i);
        return (i == 2) ? 200 : 256;
    endfunction

    function automatic bit autoinc_of(input int i);
        return (i == 1) ? 1'b0 : 1'b1;
    endfunction

    task automatic model_step(input int i, input bit r, input bit rx, input bit [1:0] op, input bit [7:0] pay);
        int d;
        d = depth_of(i);
        if (r) begin
            for (int a = 0; a < 256; a++) m_mem[i][a] = 8'h00;
            m_wr[i] = 0; m_rd[i] = 0; m_dout[i] = 8'h00; m_tx[i] = 1'b0; m_err[i] = 1'b0;
        end else begin
            m_tx[i] = 1'b0;
            if (rx) begin
                case (op)
                    2'd0: if (int'(pay) < d) m_wr[i] = int'(pay); else m_err[i] = 1'b1;
                    2'd1: begin
                        m_mem[i][m_wr[i]] = pay;
                        if (autoinc_of(i)) m_wr[i] = (m_wr[i] + 1) % d;
                    end
                    2'd2: if (int'(pay) < d) m_rd[i] = int'(pay); else m_err[i] = 1'b1;
                    default: begin
                        m_dout[i] = m_mem[i][m_rd[i]];
                        m_tx[i]   = 1'b1;
                        if (autoinc_of(i)) m_rd[i] = (m_rd[i] + 1) % d;
                    end
                endcase
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] obs(input int i);
        case (i)
            0:       return {if0.addr_err, if0.tx_valid, if0.dout};
            1:       return {if1.addr_err, if1.tx_valid, if1.dout};
            default: return {if2.addr_err, if2.tx_valid, if2.dout};
        endcase
    endfunction

    // Called at a negedge: drive, take the posedge, compare every instance at the next negedge.
    task automatic apply(input bit r, input bit rx, input bit [1:0] op, input bit [7:0] pay);
        rst   = r;
        rx_d  = rx;
        din_d = {op, pay};
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_step(i, r, rx, op, pay);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            logic [9:0] o;
            o = obs(i);
            chk($sformatf("model[%0d].dout", i),     32'(o[7:0]), 32'(m_dout[i]));
            chk($sformatf("model[%0d].tx_valid", i), 32'(o[8]),   32'(m_tx[i]));
            chk($sformatf("model[%0d].addr_err", i), 32'(o[9]),   32'(m_err[i]));
        end
    endtask

    typedef struct {
        bit       r;
        bit       rx;
        bit [1:0] op;
        bit [7:0] pay;
        bit       tx;
        bit [7:0] dout;
        bit       err;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input bit r, input bit rx, input bit [1:0] op, input bit [7:0] pay,
                                input bit tx, input bit [7:0] dout, input bit err);
        vec_t v;
        v.r = r; v.rx = rx; v.op = op; v.pay = pay; v.tx = tx; v.dout = dout; v.err = err;
        tbl.push_back(v);
    endfunction

    initial begin
        rst = 1'b1; rx_d = 1'b0; din_d = '0;
        @(negedge clk);

        // Default instance (256 words, auto-increment); expectations seen after each edge.
        add(1,0,2'd0,8'h00, 0,8'h00,0);
        add(0,1,2'd0,8'h05, 0,8'h00,0);
        add(0,1,2'd1,8'h3C, 0,8'h00,0);
        add(0,1,2'd2,8'h05, 0,8'h00,0);
        add(0,1,2'd3,8'h00, 1,8'h3C,0);
        add(1,0,2'd0,8'h00, 0,8'h00,0);
        add(0,1,2'd2,8'h05, 0,8'h00,0);
        add(0,1,2'd3,8'h00, 1,8'h00,0);
        add(0,0,2'd0,8'h00, 0,8'h00,0);
        add(0,1,2'd0,8'h0A, 0,8'h00,0);
        add(0,1,2'd1,8'hB5, 0,8'h00,0);
        add(0,1,2'd2,8'h0A, 0,8'h00,0);
        add(0,1,2'd3,8'hFF, 1,8'hB5,0);
        add(0,0,2'd0,8'h00, 0,8'hB5,0);
        add(0,1,2'd0,8'hFE, 0,8'hB5,0);
        add(0,1,2'd1,8'h11, 0,8'hB5,0);
        add(0,1,2'd1,8'h22, 0,8'hB5,0);
        add(0,1,2'd1,8'h33, 0,8'hB5,0);
        add(0,1,2'd2,8'hFE, 0,8'hB5,0);
        add(0,1,2'd3,8'h00, 1,8'h11,0);
        add(0,1,2'd3,8'h00, 1,8'h22,0);
        add(0,1,2'd3,8'h00, 1,8'h33,0);
        add(0,0,2'd0,8'h00, 0,8'h33,0);
        add(0,0,2'd3,8'h00, 0,8'h33,0);
        add(1,1,2'd1,8'h99, 0,8'h00,0);
        add(0,1,2'd2,8'h00, 0,8'h00,0);
        add(0,1,2'd3,8'h00, 1,8'h00,0);
        add(0,1,2'd1,8'h77, 0,8'h00,0);
        add(0,1,2'd2,8'h00, 0,8'h00,0);
        add(0,1,2'd3,8'h00, 1,8'h77,0);
        add(0,1,2'd0,8'hFF, 0,8'h77,0);

        foreach (tbl[k]) begin
            apply(tbl[k].r, tbl[k].rx, tbl[k].op, tbl[k].pay);
            chk($sformatf("tbl[%0d].dout", k),     32'(if0.dout),     32'(tbl[k].dout));
            chk($sformatf("tbl[%0d].tx_valid", k), 32'(if0.tx_valid), 32'(tbl[k].tx));
            chk($sformatf("tbl[%0d].addr_err", k), 32'(if0.addr_err), 32'(tbl[k].err));
        end

        // Pointers hold without auto-increment.
        apply(1,0,2'd0,8'h00);
        apply(0,1,2'd0,8'h03);
        apply(0,1,2'd1,8'h44);
        apply(0,1,2'd1,8'h55);
        apply(0,1,2'd2,8'h03);
        apply(0,1,2'd3,8'h00);
        chk("noinc.rd3", 32'(if1.dout), 32'h55);
        apply(0,1,2'd3,8'h00);
        chk("noinc.rd3_again", 32'(if1.dout), 32'h55);
        chk("noinc.tx_b2b", 32'(if1.tx_valid), 32'h1);
        apply(0,1,2'd2,8'h04);
        apply(0,1,2'd3,8'h00);
        chk("noinc.rd4", 32'(if1.dout), 32'h00);

        // 200-word instance: range error, sticky flag, wrap at 199.
        apply(1,0,2'd0,8'h00);
        apply(0,1,2'd0,8'h10);
        chk("range.ok", 32'(if2.addr_err), 32'h0);
        apply(0,1,2'd0,8'hD0);
        chk("range.bad", 32'(if2.addr_err), 32'h1);
        apply(0,1,2'd1,8'hAB);
        apply(0,1,2'd2,8'h10);
        apply(0,1,2'd3,8'h00);
        chk("range.ptr_kept", 32'(if2.dout), 32'hAB);
        apply(0,1,2'd0,8'h05);
        chk("range.sticky", 32'(if2.addr_err), 32'h1);
        apply(1,0,2'd0,8'h00);
        chk("range.rst_clears", 32'(if2.addr_err), 32'h0);
        apply(0,1,2'd0,8'hC7);
        apply(0,1,2'd1,8'h01);
        apply(0,1,2'd1,8'h02);
        apply(0,1,2'd2,8'hC7);
        apply(0,1,2'd3,8'h00);
        chk("wrap200.last", 32'(if2.dout), 32'h01);
        apply(0,1,2'd3,8'h00);
        chk("wrap200.first", 32'(if2.dout), 32'h02);
        chk("wrap200.no_err", 32'(if2.addr_err), 32'h0);
        apply(0,1,2'd2,8'hC8);
        chk("range.rd_at_depth", 32'(if2.addr_err), 32'h1);

        // Random traffic against the model, addresses clustered near 0 and the 200 boundary.
        for (int n = 0; n < 1500; n++) begin
            bit       r, rx;
            bit [1:0] op;
            bit [7:0] pay;
            r   = ($urandom_range(0, 63) == 0);
            rx  = ($urandom_range(0, 3) != 0);
            op  = 2'($urandom_range(0, 3));
            if (op == 2'd0 || op == 2'd2)
                pay = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(195, 255)) : 8'($urandom_range(0, 7));
            else
                pay = 8'($urandom_range(0, 255));
            apply(r, rx, op, pay);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
